// File: rtl/video_dither_pkg.sv
// Shared types, constants and the dither compare for the 1bpp ordered-dither stage.
// No ports; imported by video_dither_1bpp and bayer4_lut.
// Contents: CHAN_W, pos2_t, chan_t, BAYER4 threshold table, dither_bit().
package video_dither_pkg;

  localparam int CHAN_W = 4;

  typedef logic [1:0]        pos2_t;
  typedef logic [CHAN_W-1:0] chan_t;

  // Rows are indexed by y, columns by x.
  localparam logic [3:0] BAYER4 [4][4] = '{
    '{4'd0,  4'd8,  4'd2,  4'd10},
    '{4'd12, 4'd4,  4'd14, 4'd6 },
    '{4'd3,  4'd11, 4'd1,  4'd9 },
    '{4'd15, 4'd7,  4'd13, 4'd5 }
  };

  // Full scale is forced on: the largest threshold is 15, so c > T alone
  // would leave one dark pixel per tile at maximum intensity.
  function automatic logic dither_bit(input chan_t c, input chan_t t);
    return (c == 4'hF) || (c > t);
  endfunction

endpackage

// File: rtl/bayer4_lut.sv
// Purpose : 4x4 Bayer threshold lookup, T = BAYER4[yi][xi].
// Latency : combinational.
// Ports   : xi_i, yi_i (2-bit tile position) -> t_o (4-bit threshold).
module bayer4_lut
  import video_dither_pkg::*;
(
  input  logic [1:0] xi_i,
  input  logic [1:0] yi_i,
  output logic [3:0] t_o
);

  assign t_o = BAYER4[yi_i][xi_i];

endmodule

// File: rtl/video_dither_1bpp.sv
// Purpose : ordered (4x4 Bayer) dither of 4-bit RGB down to 1 bit per channel,
//           tile position recovered from vga_active / vga_vsync.
// Latency : 2 clk25 cycles for pixels, syncs and DE; no backpressure, one pixel per clock.
// Ports   : clk25, rst (sync, active-high); vga_r/g/b[3:0], vga_hsync, vga_vsync, vga_active in;
//           hdmi_red/grn/blu, hdmi_hsync, hdmi_vsync, hdmi_de out.
// Config  : define VIDEO_DITHER_TEMPORAL_EN to rotate the pattern over a 4-frame cycle.
module video_dither_1bpp
  import video_dither_pkg::*;
#(
  parameter bit SYNC_ACTIVE_HIGH = 1'b0,
  parameter bit DECORRELATE      = 1'b1
) (
  input  logic              clk25,
  input  logic              rst,
  input  logic [CHAN_W-1:0] vga_r,
  input  logic [CHAN_W-1:0] vga_g,
  input  logic [CHAN_W-1:0] vga_b,
  input  logic              vga_hsync,
  input  logic              vga_vsync,
  input  logic              vga_active,
  output logic              hdmi_red,
  output logic              hdmi_grn,
  output logic              hdmi_blu,
  output logic              hdmi_hsync,
  output logic              hdmi_vsync,
  output logic              hdmi_de
);

  // Syncs are carried internally as "1 = asserted" so that clearing the
  // pipeline to 0 always means the inactive level at the pins.
  localparam logic SYNC_INV = ~SYNC_ACTIVE_HIGH;

  logic hs_act, vs_act;
  assign hs_act = vga_hsync ^ SYNC_INV;
  assign vs_act = vga_vsync ^ SYNC_INV;

  // ---------------- stage 1: input register + position counters ----------------
  chan_t r1_q, g1_q, b1_q;
  logic  hs1_q, vs1_q, de1_q;
  pos2_t x_q, x_d, y_q, y_d;
  pos2_t xi_d, yi_d, xi1_q, yi1_q;
  logic  vs_lead, de_fall;

  // Edges are taken against the previous sample held in stage 1.
  assign vs_lead = vs_act & ~vs1_q;
  assign de_fall = de1_q & ~vga_active;

  always_comb begin
    x_d = vga_active ? x_q + 2'd1 : 2'd0;
    y_d = y_q;
    if (vs_lead) begin
      y_d = 2'd0;                 // vsync clear wins over a same-cycle line advance
    end else if (de_fall) begin
      y_d = y_q + 2'd1;
    end
  end

`ifdef VIDEO_DITHER_TEMPORAL_EN
  pos2_t frame_q, frame_d;

  assign frame_d = vs_lead ? frame_q + 2'd1 : frame_q;
  // Column offset uses the frame bits swapped so the four frames visit
  // four different tile phases rather than sliding along a diagonal.
  assign xi_d    = x_q ^ {frame_q[0], frame_q[1]};
  assign yi_d    = y_q ^ frame_q;

  always_ff @(posedge clk25) begin
    if (rst) begin
      frame_q <= 2'd0;
    end else begin
      frame_q <= frame_d;
    end
  end
`else
  assign xi_d = x_q;
  assign yi_d = y_q;
`endif

  always_ff @(posedge clk25) begin
    if (rst) begin
      r1_q  <= '0;
      g1_q  <= '0;
      b1_q  <= '0;
      hs1_q <= 1'b0;
      vs1_q <= 1'b0;
      de1_q <= 1'b0;
      x_q   <= 2'd0;
      y_q   <= 2'd0;
      xi1_q <= 2'd0;
      yi1_q <= 2'd0;
    end else begin
      r1_q  <= vga_r;
      g1_q  <= vga_g;
      b1_q  <= vga_b;
      hs1_q <= hs_act;
      vs1_q <= vs_act;
      de1_q <= vga_active;
      x_q   <= x_d;
      y_q   <= y_d;
      xi1_q <= xi_d;           // position of the pixel being captured, not the next one
      yi1_q <= yi_d;
    end
  end

  // ---------------- stage 2: threshold compare + output register ----------------
  pos2_t g_xi, g_yi, b_xi, b_yi;
  logic [3:0] t_r, t_g, t_b;

  // Green reads the transposed table, blue a half-tile-shifted copy, so the
  // three channels do not light the same sub-pixels at equal intensity.
  assign g_xi = DECORRELATE ? yi1_q : xi1_q;
  assign g_yi = DECORRELATE ? xi1_q : yi1_q;
  assign b_xi = DECORRELATE ? (xi1_q ^ 2'd2) : xi1_q;
  assign b_yi = DECORRELATE ? (yi1_q ^ 2'd2) : yi1_q;

  bayer4_lut u_lut_r (.xi_i(xi1_q), .yi_i(yi1_q), .t_o(t_r));
  bayer4_lut u_lut_g (.xi_i(g_xi),  .yi_i(g_yi),  .t_o(t_g));
  bayer4_lut u_lut_b (.xi_i(b_xi),  .yi_i(b_yi),  .t_o(t_b));

  logic red_d, grn_d, blu_d;
  logic red_q, grn_q, blu_q, hs2_q, vs2_q, de2_q;

  assign red_d = de1_q & dither_bit(r1_q, t_r);
  assign grn_d = de1_q & dither_bit(g1_q, t_g);
  assign blu_d = de1_q & dither_bit(b1_q, t_b);

  always_ff @(posedge clk25) begin
    if (rst) begin
      red_q <= 1'b0;
      grn_q <= 1'b0;
      blu_q <= 1'b0;
      hs2_q <= 1'b0;
      vs2_q <= 1'b0;
      de2_q <= 1'b0;
    end else begin
      red_q <= red_d;
      grn_q <= grn_d;
      blu_q <= blu_d;
      hs2_q <= hs1_q;
      vs2_q <= vs1_q;
      de2_q <= de1_q;
    end
  end

  assign hdmi_red   = red_q;
  assign hdmi_grn   = grn_q;
  assign hdmi_blu   = blu_q;
  assign hdmi_de    = de2_q;
  assign hdmi_hsync = hs2_q ^ SYNC_INV;
  assign hdmi_vsync = vs2_q ^ SYNC_INV;

endmodule

// File: tb/tb_video_dither_1bpp.sv
// Self-checking bench for video_dither_1bpp on a reduced raster (16x8 visible).
// A behavioural model predicts every output cycle; literal checks pin key cases.
module tb_video_dither_1bpp;

  localparam bit SAH = 1'b0;
  localparam int H_ACT = 16, H_FP = 2, H_SYNC = 3, H_BP = 3, HTOT = 24;
  localparam int V_FP = 1, V_SYNC = 2, V_BP = 1;
  localparam logic [5:0] RSTV = 6'b000011;   // {r,g,b,de,hs,vs} after reset

  logic       clk25 = 1'b0;
  logic       rst;
  logic [3:0] vga_r, vga_g, vga_b;
  logic       vga_hsync, vga_vsync, vga_active;
  logic       hdmi_red, hdmi_grn, hdmi_blu, hdmi_hsync, hdmi_vsync, hdmi_de;

  video_dither_1bpp #(.SYNC_ACTIVE_HIGH(SAH), .DECORRELATE(1'b1)) dut (
    .clk25(clk25), .rst(rst),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .vga_hsync(vga_hsync), .vga_vsync(vga_vsync), .vga_active(vga_active),
    .hdmi_red(hdmi_red), .hdmi_grn(hdmi_grn), .hdmi_blu(hdmi_blu),
    .hdmi_hsync(hdmi_hsync), .hdmi_vsync(hdmi_vsync), .hdmi_de(hdmi_de)
  );

  always #5 clk25 = ~clk25;

  int BT [4][4] = '{'{0, 8, 2, 10}, '{12, 4, 14, 6}, '{3, 11, 1, 9}, '{15, 7, 13, 5}};

  int cyc = 0;
  int cmp_cnt = 0;
  int err_cnt = 0;
  logic [5:0] exp_o = RSTV;
  logic [5:0] m1 = RSTV;
  logic [5:0] cap [0:16383];
  int col = 0, line = 0, frm = 0;
  logic prev_de = 1'b0, prev_vs = 1'b0;
  int first_px, hs_fall, rst_cyc, frame_len;

  function automatic logic lit(input int c, input int t);
    return (c == 15) || (c > t);
  endfunction

  // Model: pixel column = run length of active, line = active falls since the
  // last vsync assertion, frame = vsync assertions since reset; output 2 clocks later.
  always @(posedge clk25) begin : model
    int x, y, xi, yi;
    logic vs_a;
    cyc++;
    if (rst) begin
      exp_o = RSTV; m1 = RSTV;
      col = 0; line = 0; frm = 0; prev_de = 1'b0; prev_vs = 1'b0;
    end else begin
      exp_o = m1;
      x = col % 4; y = line % 4;
      xi = x; yi = y;
`ifdef VIDEO_DITHER_TEMPORAL_EN
      xi = x ^ (((frm % 4) & 1) * 2 + ((frm % 4) >> 1));
      yi = y ^ (frm % 4);
`endif
      m1[5] = vga_active && lit(int'(vga_r), BT[yi][xi]);
      m1[4] = vga_active && lit(int'(vga_g), BT[xi][yi]);
      m1[3] = vga_active && lit(int'(vga_b), BT[yi ^ 2][xi ^ 2]);
      m1[2] = vga_active;
      m1[1] = vga_hsync;
      m1[0] = vga_vsync;
      vs_a = (vga_vsync == SAH);
      if (vs_a && !prev_vs) begin
        line = 0; frm++;
      end else if (prev_de && !vga_active) begin
        line++;
      end
      col = vga_active ? col + 1 : 0;
      prev_de = vga_active; prev_vs = vs_a;
    end
  end

  always @(negedge clk25) begin : compare
    logic [5:0] d;
    d = {hdmi_red, hdmi_grn, hdmi_blu, hdmi_de, hdmi_hsync, hdmi_vsync};
    if (cyc < 16384) cap[cyc] = d;
    if (cyc > 0) begin
      cmp_cnt++;
      if (d !== exp_o) begin
        err_cnt++;
        if (err_cnt <= 10)
          $display("FAIL pipeline cycle %0d: got %b expected %b ({r,g,b,de,hs,vs})", cyc, d, exp_o);
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    cmp_cnt++;
    if (act != exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] r, input logic [3:0] g, input logic [3:0] b,
                       input logic hs_a, input logic vs_a, input logic de, input logic rs);
    @(posedge clk25);
    #2;
    vga_r = r; vga_g = g; vga_b = b;
    vga_hsync  = SAH ? hs_a : !hs_a;
    vga_vsync  = SAH ? vs_a : !vs_a;
    vga_active = de;
    rst        = rs;
  endtask

  task automatic idle(input int n, input logic rs);
    for (int i = 0; i < n; i++) drive(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, rs);
  endtask

  // mode 0: black, 1: full, 2: random, 3: mid-grey 8, 4: red=1 with random g/b
  task automatic drive_frame(input int mode, input int nact, input int rst_line, input int rst_px);
    int vtot;
    logic [3:0] r, g, b;
    logic hs_a, vs_a, de, rs;
    vtot = nact + V_FP + V_SYNC + V_BP;
    for (int l = 0; l < vtot; l++) begin
      for (int p = 0; p < HTOT; p++) begin
        de   = (l < nact) && (p < H_ACT);
        hs_a = (p >= H_ACT + H_FP) && (p < H_ACT + H_FP + H_SYNC);
        vs_a = (l >= nact + V_FP) && (l < nact + V_FP + V_SYNC);
        rs   = (l == rst_line) && (p == rst_px);
        case (mode)
          0:       begin r = 4'd0;  g = 4'd0;  b = 4'd0;  end
          1:       begin r = 4'd15; g = 4'd15; b = 4'd15; end
          3:       begin r = 4'd8;  g = 4'd8;  b = 4'd8;  end
          4:       begin r = 4'd1;  g = 4'($urandom_range(0, 15)); b = 4'($urandom_range(0, 15)); end
          default: begin
            r = 4'($urandom_range(0, 15)); g = 4'($urandom_range(0, 15)); b = 4'($urandom_range(0, 15));
          end
        endcase
        drive(r, g, b, hs_a, vs_a, de, rs);
        if (l == 0 && p == 0) first_px = cyc;
        if (l == 0 && p == H_ACT + H_FP) hs_fall = cyc;
        if (rs) rst_cyc = cyc;
      end
    end
    frame_len = vtot * HTOT;
  endtask

  function automatic int count_bit(input int start, input int len, input int bi);
    int n = 0;
    for (int i = 0; i < len; i++) n += int'(cap[start + i][bi]);
    return n;
  endfunction

  initial begin
    int exp3 [4] = '{1, 0, 1, 0};
`ifdef VIDEO_DITHER_TEMPORAL_EN
    int exp7 [4] = '{1, 0, 0, 1};
    int exp5 = 0;
`else
    int exp7 [4] = '{1, 1, 1, 1};
    int exp5 = 1;
`endif
    int n;
    rst = 1'b1; vga_r = 4'd0; vga_g = 4'd0; vga_b = 4'd0;
    vga_hsync = !SAH; vga_vsync = !SAH; vga_active = 1'b0;
    idle(2, 1'b1);
    idle(4, 1'b0);
    check("reset_state", int'(cap[2]), int'(RSTV));

    // Static pattern, first frame after reset: row 0 of the table at grey 8.
    drive_frame(3, 8, -1, -1);
    for (int i = 0; i < 4; i++)
      check($sformatf("grey8_line0_px%0d", i), int'(cap[first_px + 2 + i][5]), exp3[i]);
    n = 0;
    for (int l = 0; l < 4; l++)
      for (int i = 0; i < 4; i++) n += int'(cap[first_px + 2 + l * HTOT + i][5]);
    check("grey8_tile_ones", n, 8);
    check("hsync_before", int'(cap[hs_fall + 1][1]), 1);
    check("hsync_latency", int'(cap[hs_fall + 2][1]), 0);
    check("de_before", int'(cap[first_px + 1][2]), 0);
    check("de_latency", int'(cap[first_px + 2][2]), 1);

    drive_frame(0, 8, -1, -1);
    check("black_red", count_bit(first_px + 2, frame_len, 5), 0);
    check("black_grn", count_bit(first_px + 2, frame_len, 4), 0);
    check("black_blu", count_bit(first_px + 2, frame_len, 3), 0);

    drive_frame(1, 8, -1, -1);
    check("full_red", count_bit(first_px + 2, frame_len, 5), H_ACT * 8);
    check("full_grn", count_bit(first_px + 2, frame_len, 4), H_ACT * 8);
    check("full_blu", count_bit(first_px + 2, frame_len, 3), H_ACT * 8);
    check("full_de", count_bit(first_px + 2, frame_len, 2), H_ACT * 8);

    repeat (3) drive_frame(2, 8, -1, -1);

    // Short frame leaves y at 3; the vsync must bring the next line back to y=0.
    idle(1, 1'b1);
    idle(2, 1'b0);
    drive_frame(4, 3, -1, -1);
    drive_frame(4, 8, -1, -1);
    check("y_after_vsync", int'(cap[first_px + 2][5]), exp5);

    // Reset in the middle of an active line.
    drive_frame(3, 8, 1, 5);
    check("midline_rst_out1", int'(cap[rst_cyc + 1]), int'(RSTV));
    check("midline_rst_out2", int'(cap[rst_cyc + 2]), int'(RSTV));
    check("midline_rst_red", int'(cap[rst_cyc + 3][5]), 1);
    check("midline_rst_de", int'(cap[rst_cyc + 3][2]), 1);

    // Pixel (0,0) at grey 8 across four consecutive frames.
    idle(1, 1'b1);
    idle(2, 1'b0);
    for (int k = 0; k < 4; k++) begin
      drive_frame(3, 8, -1, -1);
      check($sformatf("frame%0d_px00", k), int'(cap[first_px + 2][5]), exp7[k]);
    end

    idle(4, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
